// File: rtl/time_entry_pkg.sv
// Shared types, digit limits and select encodings for the M:SS time entry editor.
package time_entry_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EDIT_MIN  = 2'd1,
      ST_EDIT_TENS = 2'd2,
      ST_EDIT_ONES = 2'd3
   } state_t;

   localparam logic [3:0] MIN_LIMIT  = 4'd9;
   localparam logic [3:0] TENS_LIMIT = 4'd5;
   localparam logic [3:0] ONES_LIMIT = 4'd9;

   localparam logic [1:0] SEL_MIN  = 2'd2;
   localparam logic [1:0] SEL_TENS = 2'd1;
   localparam logic [1:0] SEL_ONES = 2'd0;

   typedef struct packed {
      logic [3:0] min;
      logic [3:0] tens;
      logic [3:0] ones;
   } mss_t;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? 4'd0 : d;
   endfunction

   function automatic mss_t sanitize(input mss_t v);
      mss_t r;
      r.min  = clamp_digit(v.min, MIN_LIMIT);
      r.tens = clamp_digit(v.tens, TENS_LIMIT);
      r.ones = clamp_digit(v.ones, ONES_LIMIT);
      return r;
   endfunction

   // Wrapping step within 0..lim; digits never carry into their neighbours.
   function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] lim,
                                             input logic inc);
      if (inc) return (d >= lim) ? 4'd0 : d + 4'd1;
      else     return (d == 4'd0) ? lim : d - 4'd1;
   endfunction

   function automatic logic [1:0] sel_of(input state_t s);
      case (s)
         ST_EDIT_MIN:  return SEL_MIN;
         ST_EDIT_TENS: return SEL_TENS;
         default:      return SEL_ONES;
      endcase
   endfunction

endpackage

// File: rtl/time_entry_editor_if.sv
// Button/preset inputs and display-side outputs of the time entry editor.
interface time_entry_editor_if;
   logic        edit_btn;
   logic        up_btn;
   logic        down_btn;
   logic        cancel_btn;
   logic [11:0] preset;
   logic [11:0] bcd_out;
   logic        load;
   logic        editing;
   logic [1:0]  sel_digit;
   logic [2:0]  blank_mask;
   logic [11:0] work;

   modport master (
      output edit_btn, up_btn, down_btn, cancel_btn, preset,
      input  bcd_out, load, editing, sel_digit, blank_mask, work
   );

   modport slave (
      input  edit_btn, up_btn, down_btn, cancel_btn, preset,
      output bcd_out, load, editing, sel_digit, blank_mask, work
   );
endinterface

// File: rtl/blink_gen.sv
// Free-running blink phase generator; restart forces the visible phase and a fresh period.
module blink_gen #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic phase
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] cnt;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CW'(PERIOD - 1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/time_entry_editor.sv
// Digit-by-digit M:SS editor: capture preset, step digits with wrap, commit or abandon.
module time_entry_editor
   import time_entry_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BLINK_HZ  = 2,
   parameter int TIMEOUT_S = 10
) (
   input  logic clk,
   input  logic rst,
   time_entry_editor_if.slave bus
);

   localparam int     BLINK_PERIOD = CLK_HZ / (2 * BLINK_HZ);
   localparam longint TMO_CYCLES   = longint'(TIMEOUT_S) * longint'(CLK_HZ);
   localparam int     TW           = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

   state_t        state, state_next;
   mss_t          work_q, work_next, bcd_q;
   logic          load_q, editing_q, editing_next;
   logic [1:0]    sel_q, sel_next;
   logic [TW-1:0] tmo_cnt;
   logic          phase;

   logic in_edit, any_btn, tmo_hit;
   logic start, abort, advance, step_up, step_dn, commit, restart;

   // Priority: cancel (or timeout) beats edit, which beats up/down.
   assign in_edit = (state != ST_IDLE);
   assign any_btn = bus.edit_btn | bus.up_btn | bus.down_btn | bus.cancel_btn;
   assign tmo_hit = in_edit & ~any_btn & (tmo_cnt == TMO_LAST);
   assign start   = ~in_edit & bus.edit_btn;
   assign abort   = in_edit & (bus.cancel_btn | tmo_hit);
   assign advance = in_edit & ~bus.cancel_btn & bus.edit_btn;
   assign step_up = in_edit & ~bus.cancel_btn & ~bus.edit_btn & bus.up_btn & ~bus.down_btn;
   assign step_dn = in_edit & ~bus.cancel_btn & ~bus.edit_btn & bus.down_btn & ~bus.up_btn;
   assign commit  = advance & (state == ST_EDIT_ONES);
   assign restart = step_up | step_dn | (state_next != state);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latches).
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = ST_EDIT_MIN;
      end else if (abort) begin
         state_next = ST_IDLE;
      end else if (advance) begin
         case (state)
            ST_EDIT_MIN:  state_next = ST_EDIT_TENS;
            ST_EDIT_TENS: state_next = ST_EDIT_ONES;
            default:      state_next = ST_IDLE;
         endcase
      end
   end

   // Decoded from the next state so the registered copies move on the same edge as state.
   always_comb begin
      editing_next = (state_next != ST_IDLE);
      sel_next     = (state_next == ST_IDLE) ? SEL_ONES : sel_of(state_next);
   end

   always_comb begin
      work_next = work_q;
      if (start) begin
         work_next = sanitize(mss_t'(bus.preset));
      end else if (abort) begin
         work_next = bcd_q;
      end else if (step_up || step_dn) begin
         case (state)
            ST_EDIT_MIN:  work_next.min  = step_digit(work_q.min,  MIN_LIMIT,  step_up);
            ST_EDIT_TENS: work_next.tens = step_digit(work_q.tens, TENS_LIMIT, step_up);
            ST_EDIT_ONES: work_next.ones = step_digit(work_q.ones, ONES_LIMIT, step_up);
            default:      work_next = work_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q    <= '0;
         bcd_q     <= '0;
         load_q    <= 1'b0;
         editing_q <= 1'b0;
         sel_q     <= SEL_ONES;
         tmo_cnt   <= '0;
      end else begin
         work_q    <= work_next;
         load_q    <= commit;
         editing_q <= editing_next;
         sel_q     <= sel_next;
         if (commit) bcd_q <= work_q;
         tmo_cnt   <= (state_next == ST_IDLE || any_btn) ? '0 : tmo_cnt + TW'(1);
      end
   end

   blink_gen #(.PERIOD(BLINK_PERIOD)) u_blink (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .phase   (phase)
   );

   assign bus.bcd_out    = bcd_q;
   assign bus.work       = work_q;
   assign bus.load       = load_q;
   assign bus.editing    = editing_q;
   assign bus.sel_digit  = sel_q;
   assign bus.blank_mask = editing_q ? (3'(phase) << sel_q) : 3'b000;

endmodule

// File: doc/time_entry_editor.md
TIME_ENTRY_EDITOR -- requirements
Module: time_entry_editor

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 2, blink rate of the selected digit in Hz.
REQ-003 Parameter TIMEOUT_S, default 10, idle seconds before an edit session is abandoned.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 edit_btn  in  1  single-cycle pulse; start edit, advance digit, commit.
REQ-007 up_btn  in  1  single-cycle pulse; increment selected digit.
REQ-008 down_btn  in  1  single-cycle pulse; decrement selected digit.
REQ-009 cancel_btn  in  1  single-cycle pulse; abandon edit.
REQ-010 preset  in  12  current M:SS BCD {min, sec_tens, sec_ones}, captured at edit start.
REQ-011 bcd_out  out  12  committed M:SS BCD, same packing as preset.
REQ-012 load  out  1  single-cycle pulse, bcd_out newly committed.
REQ-013 editing  out  1  high while in any EDIT state.
REQ-014 sel_digit  out  2  selected digit: 2=min, 1=sec_tens, 0=sec_ones; 0 in IDLE.
REQ-015 blank_mask  out  3  per-digit blank request (bit i = digit i), for the display mux.
REQ-016 work  out  12  working value under edit; equals bcd_out in IDLE.

Function
REQ-017 States: IDLE, EDIT_MIN, EDIT_TENS, EDIT_ONES.
REQ-018 IDLE + edit_btn -> EDIT_MIN; work <= preset, each digit over its limit (min>9, tens>5, ones>9) captured as 0.
REQ-019 edit_btn: EDIT_MIN -> EDIT_TENS -> EDIT_ONES; edit_btn in EDIT_ONES -> IDLE, bcd_out <= work, load=1 the next cycle only.
REQ-020 cancel_btn in any EDIT state -> IDLE, bcd_out unchanged, load stays 0; work reverts to bcd_out.
REQ-021 Input priority per cycle: cancel_btn > edit_btn > up_btn/down_btn; lower-priority pulses in that cycle are ignored.
REQ-022 up_btn and down_btn in the same cycle: no change.
REQ-023 Digit ranges with wrap: min 0..9 (9+1=0, 0-1=9), sec_tens 0..5 (5+1=0, 0-1=5), sec_ones 0..9; no carry or borrow between digits.
REQ-024 up/down/cancel in IDLE ignored; no output changes.
REQ-025 Blink counter period CLK_HZ/(2*BLINK_HZ) cycles toggles phase; blank_mask[sel_digit]=phase in EDIT states, all other bits 0; blank_mask=0 in IDLE.
REQ-026 Any accepted button pulse, or any state entry, restarts the blink counter with phase=0 (digit visible) next cycle.
REQ-027 Timeout counter counts cycles in EDIT states, cleared by any button pulse; reaching TIMEOUT_S*CLK_HZ cycles behaves exactly as cancel_btn.
REQ-028 editing and sel_digit are registered and reflect the current state; they change on the same edge as the state.
REQ-029 load never asserts in two consecutive cycles.

Reset
REQ-030 rst (sampled on clk) forces state IDLE, bcd_out=0, work=0, load=0, editing=0, sel_digit=0, blank_mask=0, blink and timeout counters=0.
REQ-031 rst mid-edit discards work with no load pulse; rst has priority over all button inputs in the same cycle.

Structure
REQ-032 Package time_entry_pkg holds the state enum, digit limits (9, 5, 9), and sel_digit encodings.
REQ-033 One sub-module blink_gen (counter, phase, restart input) is instantiated; all other logic resides in time_entry_editor.

Verification (CLK_HZ=16, BLINK_HZ=2, TIMEOUT_S=10 for simulation)
REQ-034 preset=12'h345, edit, up, edit, down x2, edit, up, edit -> one load pulse, bcd_out=12'h426.
REQ-035 preset=12'h9F9, edit -> work=12'h909; up on min -> min=0; on tens down from 0 -> tens=5.
REQ-036 edit, up, then cancel_btn and up_btn in the same cycle -> IDLE, no load, bcd_out unchanged, work=bcd_out.
REQ-037 In EDIT_TENS with no input -> blank_mask toggles 3'b000/3'b010 every 4 cycles; up pulse -> 3'b000 the next cycle, period restarts.
REQ-038 Enter edit, no input for 160 cycles -> IDLE at cycle 160, no load; a button at cycle 159 restarts the count.
REQ-039 rst asserted in EDIT_ONES, coinciding with edit_btn -> next cycle IDLE, bcd_out=0, load=0.
